alu_muldiv_sequencer: RTL and testbench

//  Iterative unsigned multiply/divide controller for the EX stage. It borrows the shared 32-bit ALU
//  (AND 000, OR 001, ADD 010, SUB 110, SLT 111) for one add/sub per cycle.
//  It drives shift-add MULTU and restoring DIVU into HI/LO and stalls the pipeline while it owns the ALU.
//  The top-level EX mux selects the sequencer's ALU operands whenever alu_own=1.

---
 rtl/alu_muldiv_sequencer_if.sv | 43 ++++
 rtl/alu_muldiv_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_sequencer_if.sv
// Bus between the EX stage and the multiply/divide sequencer.
// Optional signed support adds op_signed when MULDIV_SIGNED_EN is defined.
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
`ifdef MULDIV_SIGNED_EN
  logic             op_signed;
`endif
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_own;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULDIV_SIGNED_EN
  modport master (
    output start, op_div, op_signed, src_a, src_b, alu_result, alu_cout,
    input  alu_a, alu_b, alu_op, alu_own, stall, done, hi, lo
  );
  modport slave (
    input  start, op_div, op_signed, src_a, src_b, alu_result, alu_cout,
    output alu_a, alu_b, alu_op, alu_own, stall, done, hi, lo
  );
`else
  modport master (
    output start, op_div, src_a, src_b, alu_result, alu_cout,
    input  alu_a, alu_b, alu_op, alu_own, stall, done, hi, lo
  );
  modport slave (
    input  start, op_div, src_a, src_b, alu_result, alu_cout,
    output alu_a, alu_b, alu_op, alu_own, stall, done, hi, lo
  );
`endif
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Iterative MULTU / DIVU sequencer that borrows the shared EX ALU for one
// add or subtract per cycle and stalls the pipeline while it owns it.
// Optional feature macro: MULDIV_SIGNED_EN (signed ops via PRE/POST states).
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                rst,
  alu_muldiv_sequencer_if.slave bus
);

  localparam logic [2:0]       OP_ADD = 3'b010;
  localparam logic [2:0]       OP_SUB = 3'b110;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE, S_PRE, S_POST
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] acc;    // multiply accumulator / divide remainder
  logic [WIDTH-1:0] mq;     // multiplier / quotient shift register
  logic [WIDTH-1:0] mcand;  // multiplicand / divisor
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_r, lo_r;

`ifdef MULDIV_SIGNED_EN
  logic signed_r, op_div_r, sgn_a, sgn_b, post_ph, lo_zero;
`endif

  logic             div_zero, last;
  logic             mul_c, div_take;
  logic [WIDTH-1:0] mul_s, mul_acc_nx, mul_mq_nx;
  logic [WIDTH-1:0] div_sh, div_rem_nx, div_q_nx;

  logic             own, stall, done;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;

  assign div_zero = bus.op_div && (bus.src_b == '0);
  assign last     = (cnt == LAST);

  // Shift-add step: add multiplicand only when the current multiplier bit is 1.
  assign mul_c      = mq[0] & bus.alu_cout;
  assign mul_s      = mq[0] ? bus.alu_result : acc;
  assign mul_acc_nx = {mul_c, mul_s[WIDTH-1:1]};
  assign mul_mq_nx  = {mul_s[0], mq[WIDTH-1:1]};

  // Restoring divide step: a set remainder msb means the shifted value
  // already exceeds any divisor, so the subtract is always taken.
  assign div_sh     = {acc[WIDTH-2:0], mq[WIDTH-1]};
  assign div_take   = acc[WIDTH-1] | bus.alu_cout;
  assign div_rem_nx = div_take ? bus.alu_result : div_sh;
  assign div_q_nx   = {mq[WIDTH-2:0], div_take};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) begin
        if (div_zero)          state_nx = S_DONE;
`ifdef MULDIV_SIGNED_EN
        else if (bus.op_signed) state_nx = S_PRE;
`endif
        else                   state_nx = bus.op_div ? S_DIV : S_MUL;
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE:  state_nx = op_div_r ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (last) state_nx = signed_r ? S_POST : S_DONE;
      S_POST: if (op_div_r || post_ph) state_nx = S_DONE;
`else
      S_MUL,
      S_DIV:  if (last) state_nx = S_DONE;
`endif
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs: ALU operands, ownership, stall and done
  always_comb begin
    own    = 1'b0;
    stall  = 1'b0;
    done   = 1'b0;
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    case (state)
      S_IDLE: stall = bus.start;
      S_MUL: begin
        own = 1'b1; stall = 1'b1;
        alu_a = acc; alu_b = mcand; alu_op = OP_ADD;
      end
      S_DIV: begin
        own = 1'b1; stall = 1'b1;
        alu_a = div_sh; alu_b = mcand; alu_op = OP_SUB;
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE: begin
        own = 1'b1; stall = 1'b1;
        alu_a = '0; alu_b = mq; alu_op = OP_SUB;
      end
      S_POST: begin
        own = 1'b1; stall = 1'b1; alu_op = OP_SUB;
        if (!op_div_r && post_ph) begin
          // ~hi - (-1) = ~hi + 1 carries the low-word borrow into hi
          alu_a = ~acc;
          alu_b = lo_zero ? '1 : '0;
        end else begin
          alu_a = '0;
          alu_b = mq;
        end
      end
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
`ifdef MULDIV_SIGNED_EN
      signed_r <= 1'b0; op_div_r <= 1'b0; sgn_a <= 1'b0;
      sgn_b    <= 1'b0; post_ph  <= 1'b0; lo_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          acc   <= '0;
          mq    <= bus.src_a;
          mcand <= bus.src_b;
          cnt   <= '0;
          if (div_zero) begin
            hi_r <= bus.src_a;
            lo_r <= '1;
          end
`ifdef MULDIV_SIGNED_EN
          signed_r <= bus.op_signed;
          op_div_r <= bus.op_div;
          sgn_a    <= bus.op_signed & bus.src_a[WIDTH-1];
          sgn_b    <= bus.op_signed & bus.src_b[WIDTH-1];
          post_ph  <= 1'b0;
`endif
        end
        S_MUL: begin
          acc <= mul_acc_nx;
          mq  <= mul_mq_nx;
          cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_SIGNED_EN
          if (last && !signed_r) begin
`else
          if (last) begin
`endif
            hi_r <= mul_acc_nx;
            lo_r <= mul_mq_nx;
          end
        end
        S_DIV: begin
          acc <= div_rem_nx;
          mq  <= div_q_nx;
          cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_SIGNED_EN
          if (last && !signed_r) begin
`else
          if (last) begin
`endif
            hi_r <= div_rem_nx;
            lo_r <= div_q_nx;
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_PRE: begin
          if (sgn_a) mq <= bus.alu_result;
          if (sgn_b) mcand <= '0 - mcand;
        end
        S_POST: begin
          if (op_div_r) begin
            lo_r <= (sgn_a ^ sgn_b) ? bus.alu_result : mq;
            hi_r <= sgn_a ? ('0 - acc) : acc;
          end else if (!post_ph) begin
            post_ph <= 1'b1;
            lo_zero <= (mq == '0);
            if (sgn_a ^ sgn_b) mq <= bus.alu_result;
          end else begin
            lo_r <= mq;
            hi_r <= (sgn_a ^ sgn_b) ? bus.alu_result : acc;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_op  = alu_op;
  assign bus.alu_own = own;
  assign bus.stall   = stall;
  assign bus.done    = done;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer (unsigned build): a shared
// ALU model, a timeline reference model, directed literal cases and
// randomized traffic with spurious start pulses.
module tb_alu_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  alu_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared EX ALU
  always_comb begin
    logic [W:0] t;
    t = '0;
    case (bus.alu_op)
      3'b000:  t = {1'b0, bus.alu_a & bus.alu_b};
      3'b001:  t = {1'b0, bus.alu_a | bus.alu_b};
      3'b010:  t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b110:  t = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
      3'b111:  t = {{W{1'b0}}, (bus.alu_a < bus.alu_b)};
      default: t = '0;
    endcase
    bus.alu_result = t[W-1:0];
    bus.alu_cout   = t[W];
  end

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 iterating, 2 done cycle
  int         m_st   = 0;
  int         m_iter = 0;
  logic       m_div  = 1'b0;
  logic [W-1:0] m_b = '0, m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

  task automatic model_step();
    logic [2*W-1:0] p;
    if (rst) begin
      m_st = 0; m_hi = '0; m_lo = '0;
    end else begin
      case (m_st)
        0: if (bus.start) begin
          m_div = bus.op_div;
          m_b   = bus.src_b;
          if (bus.op_div && bus.src_b == '0) begin
            m_st = 2; m_hi = bus.src_a; m_lo = '1;
          end else begin
            m_st = 1; m_iter = 1;
            if (bus.op_div) begin
              r_lo = bus.src_a / bus.src_b;
              r_hi = bus.src_a % bus.src_b;
            end else begin
              p = 64'(bus.src_a) * 64'(bus.src_b);
              r_hi = p[2*W-1:W];
              r_lo = p[W-1:0];
            end
          end
        end
        1: if (m_iter == W) begin
          m_st = 2; m_hi = r_hi; m_lo = r_lo;
        end else m_iter++;
        default: m_st = 0;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, observe done mid-cycle, advance model
  task automatic cycle(input logic r, input logic st, input logic od,
                       input logic [W-1:0] a, input logic [W-1:0] b, output logic d);
    rst = r; bus.start = st; bus.op_div = od; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    d = bus.done;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    logic iter;
    if (chk_en && !rst) begin
      iter = (m_st == 1);
      chk("stall", 64'(bus.stall), 64'(iter || (m_st == 0 && bus.start)));
      chk("alu_own", 64'(bus.alu_own), 64'(iter));
      chk("done", 64'(bus.done), 64'(m_st == 2));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      if (iter) begin
        chk("alu_op", 64'(bus.alu_op), 64'(m_div ? 3'b110 : 3'b010));
        chk("alu_b", 64'(bus.alu_b), 64'(m_b));
      end else begin
        chk("alu_op_idle", 64'(bus.alu_op), 64'(0));
        chk("alu_ab_idle", {bus.alu_a, bus.alu_b}, 64'(0));
      end
    end
  end

  // Run one op to completion and pin latency and results to literals
  task automatic run_op(input string nm, input logic od, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    logic d;
    int   seen;
    seen = -1;
    cycle(1'b0, 1'b1, od, a, b, d);
    for (int i = 1; i <= W + 4 && seen < 0; i++) begin
      cycle(1'b0, 1'b0, od, a, b, d);
      if (d) seen = i;
    end
    chk({nm, "_latency"}, 64'(seen), 64'(lat));
    chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return W'($urandom_range(0, 15));
      1:       return '1;
      2:       return 32'h8000_0000 | $urandom;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic         d, op;
    logic [W-1:0] a, b;
    int           ndone, seen, guard;

    bus.start = 1'b0; bus.op_div = 1'b0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, '0, d);
    chk("reset_hi", 64'(bus.hi), 64'(0));
    chk("reset_lo", 64'(bus.lo), 64'(0));
    chk("reset_stall", 64'(bus.stall), 64'(0));
    chk("reset_alu_op", 64'(bus.alu_op), 64'(0));
    chk_en = 1'b1;

    // Directed cases with hand-computed results
    run_op("mul_7x6",   1'b0, 32'd7,         32'd6,         33, 32'd0,         32'd42);
    run_op("mul_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_100_7", 1'b1, 32'd100,       32'd7,         33, 32'd2,         32'd14);
    run_op("div_msb",   1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'h7FFF_FFFE, 32'd1);
    run_op("div_zero",  1'b1, 32'd5,         32'd0,         1,  32'd5,         32'hFFFF_FFFF);

    // Abort at iteration 10, then hammer start while busy
    cycle(1'b0, 1'b1, 1'b0, 32'h1234, 32'h5678, d);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, d);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, d);
    chk("abort_hi", 64'(bus.hi), 64'(0));
    chk("abort_lo", 64'(bus.lo), 64'(0));
    ndone = 0; seen = -1;
    for (int i = 0; i <= W + 1; i++) begin
      cycle(1'b0, 1'b1, 1'b0, (i == 0) ? 32'd3 : 32'd9, (i == 0) ? 32'd5 : 32'd9, d);
      if (d) begin ndone++; seen = i; end
    end
    chk("abort_done_count", 64'(ndone), 64'(1));
    chk("abort_done_cycle", 64'(seen), 64'(33));
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0, '0, d);
    chk("abort_lo_hold", 64'(bus.lo), 64'(15));
    chk("abort_hi_hold", 64'(bus.hi), 64'(0));

    // Randomized traffic with spurious starts while busy
    repeat (150) begin
      op = 1'($urandom_range(0, 1));
      a  = rnd_operand();
      b  = rnd_operand();
      if (op && $urandom_range(0, 7) == 0) b = '0;
      cycle(1'b0, 1'b1, op, a, b, d);
      guard = 0;
      while (m_st != 0 && guard < 60) begin
        cycle(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              $urandom, rnd_operand(), d);
        guard++;
      end
      if (guard >= 60) chk("random_timeout", 64'(guard), 64'(0));
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0, '0, '0, d);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
